// File: rtl/sram_rule_arbiter.sv
// Single-port SRAM arbiter between a lookup read stream and a config read/write stream.
// Optional watchdog enabled by defining ARB_TIMEOUT_EN.
module sram_rule_arbiter #(
  parameter int SRAM_ADDR_WIDTH   = 19,
  parameter int SRAM_DATA_WIDTH   = 72,
  parameter int MAX_LOOKUP_STREAK = 4,
  parameter int TIMEOUT_CYCLES    = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       lk_req,
  input  logic [SRAM_ADDR_WIDTH-1:0] lk_addr,
  output logic                       lk_gnt,
  output logic                       lk_vld,
  input  logic                       cfg_req,
  input  logic                       cfg_rd_wr_L,
  input  logic [SRAM_ADDR_WIDTH-1:0] cfg_addr,
  input  logic [SRAM_DATA_WIDTH-1:0] cfg_wr_data,
  output logic                       cfg_gnt,
  output logic                       cfg_done,
  output logic [SRAM_DATA_WIDTH-1:0] rsp_data,
  output logic                       rsp_err,
  output logic                       rd_0_req,
  output logic [SRAM_ADDR_WIDTH-1:0] rd_0_addr,
  input  logic [SRAM_DATA_WIDTH-1:0] rd_0_data,
  input  logic                       rd_0_ack,
  input  logic                       rd_0_vld,
  output logic                       wr_0_req,
  output logic [SRAM_ADDR_WIDTH-1:0] wr_0_addr,
  output logic [SRAM_DATA_WIDTH-1:0] wr_0_data,
  input  logic                       wr_0_ack
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_REQ  = 2'd1;
  localparam logic [1:0] RD_DATA = 2'd2;
  localparam logic [1:0] WR_REQ  = 2'd3;

  localparam int STREAK_W = $clog2(MAX_LOOKUP_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LOOKUP_STREAK);

  logic [1:0]          state;
  logic                owner_cfg;
  logic [STREAK_W-1:0] streak;
  logic                streak_full;
  logic                lk_win;
  logic                cfg_win;

  function automatic logic [STREAK_W-1:0] sat_inc(input logic [STREAK_W-1:0] v);
    return (v == STREAK_MAX) ? v : v + 1'b1;
  endfunction

  // cfg only overtakes lookups once lookups have used up their streak allowance
  always_comb begin
    streak_full = (streak == STREAK_MAX);
    lk_win      = lk_req && !(cfg_req && streak_full);
    cfg_win     = cfg_req && !lk_win;
  end

`ifdef ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_cnt;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      owner_cfg <= 1'b0;
      streak    <= '0;
      lk_gnt    <= 1'b0;
      lk_vld    <= 1'b0;
      cfg_gnt   <= 1'b0;
      cfg_done  <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      rd_0_req  <= 1'b0;
      rd_0_addr <= '0;
      wr_0_req  <= 1'b0;
      wr_0_addr <= '0;
      wr_0_data <= '0;
`ifdef ARB_TIMEOUT_EN
      wd_cnt    <= '0;
`endif
    end else begin
      lk_gnt   <= 1'b0;
      lk_vld   <= 1'b0;
      cfg_gnt  <= 1'b0;
      cfg_done <= 1'b0;
      if (!cfg_req) streak <= '0;

      case (state)
        IDLE: begin
          if (lk_win) begin
            lk_gnt    <= 1'b1;
            owner_cfg <= 1'b0;
            rd_0_addr <= lk_addr;
            state     <= RD_REQ;
            if (cfg_req) streak <= sat_inc(streak);
          end else if (cfg_win) begin
            cfg_gnt   <= 1'b1;
            owner_cfg <= 1'b1;
            streak    <= '0;
            if (cfg_rd_wr_L) begin
              rd_0_addr <= cfg_addr;
              state     <= RD_REQ;
            end else begin
              wr_0_addr <= cfg_addr;
              wr_0_data <= cfg_wr_data;
              state     <= WR_REQ;
            end
          end
        end
        // request rises the cycle after the grant; ack is only honoured once it is up
        RD_REQ: begin
          if (rd_0_req && rd_0_ack) begin
            rd_0_req <= 1'b0;
            if (rd_0_vld) begin
              rsp_data <= rd_0_data;
              rsp_err  <= 1'b0;
              lk_vld   <= !owner_cfg;
              cfg_done <= owner_cfg;
              state    <= IDLE;
            end else begin
              state <= RD_DATA;
            end
          end else begin
            rd_0_req <= 1'b1;
          end
        end
        RD_DATA: begin
          if (rd_0_vld) begin
            rsp_data <= rd_0_data;
            rsp_err  <= 1'b0;
            lk_vld   <= !owner_cfg;
            cfg_done <= owner_cfg;
            state    <= IDLE;
          end
        end
        WR_REQ: begin
          if (wr_0_req && wr_0_ack) begin
            wr_0_req <= 1'b0;
            rsp_err  <= 1'b0;
            cfg_done <= 1'b1;
            state    <= IDLE;
          end else begin
            wr_0_req <= 1'b1;
          end
        end
      endcase

`ifdef ARB_TIMEOUT_EN
      // abort overrides whatever the state machine decided this cycle
      if (state != IDLE) begin
        if (wd_cnt == WD_LAST) begin
          wd_cnt   <= '0;
          rd_0_req <= 1'b0;
          wr_0_req <= 1'b0;
          rsp_data <= '0;
          rsp_err  <= 1'b1;
          lk_vld   <= !owner_cfg;
          cfg_done <= owner_cfg;
          state    <= IDLE;
        end else begin
          wd_cnt <= wd_cnt + 1'b1;
        end
      end else begin
        wd_cnt <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_sram_rule_arbiter.sv
// Scoreboard bench for sram_rule_arbiter: directed stimulus, SRAM responder, decoupled monitor.
module tb_sram_rule_arbiter;
  localparam int AW = 19;
  localparam int DW = 72;
  localparam byte GL = 8'h4C;
  localparam byte GC = 8'h43;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic lk_req = 1'b0, cfg_req = 1'b0, cfg_rd_wr_L = 1'b0;
  logic [AW-1:0] lk_addr = '0, cfg_addr = '0;
  logic [DW-1:0] cfg_wr_data = '0;
  logic lk_gnt, lk_vld, cfg_gnt, cfg_done, rsp_err;
  logic [DW-1:0] rsp_data;
  logic rd_0_req, wr_0_req;
  logic [AW-1:0] rd_0_addr, wr_0_addr;
  logic [DW-1:0] wr_0_data;
  logic [DW-1:0] rd_0_data = '0;
  logic rd_0_ack = 1'b0, rd_0_vld = 1'b0, wr_0_ack = 1'b0;

  always #5 clk = ~clk;

  sram_rule_arbiter dut (
    .clk(clk), .reset(reset),
    .lk_req(lk_req), .lk_addr(lk_addr), .lk_gnt(lk_gnt), .lk_vld(lk_vld),
    .cfg_req(cfg_req), .cfg_rd_wr_L(cfg_rd_wr_L), .cfg_addr(cfg_addr),
    .cfg_wr_data(cfg_wr_data), .cfg_gnt(cfg_gnt), .cfg_done(cfg_done),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .rd_0_req(rd_0_req), .rd_0_addr(rd_0_addr), .rd_0_data(rd_0_data),
    .rd_0_ack(rd_0_ack), .rd_0_vld(rd_0_vld),
    .wr_0_req(wr_0_req), .wr_0_addr(wr_0_addr), .wr_0_data(wr_0_data),
    .wr_0_ack(wr_0_ack)
  );

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    bit            is_cfg;
    bit            chk_data;
    logic [DW-1:0] data;
    bit            err;
  } rsp_t;

  rsp_t exp_rsp[$];
  byte  exp_gnt[$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // SRAM responder: latencies counted from the first cycle the request is seen high
  int ack_lat = 0, vld_lat = 0, wack_lat = 0;
  bit sram_en = 1'b1;
  logic [DW-1:0] rd_val = '0;
  logic [AW-1:0] exp_rd_addr = '0, exp_wr_addr = '0;
  logic [DW-1:0] exp_wr_data = '0;
  int wr_hi = 0;

  initial begin
    int rcnt, wcnt, vcnt;
    rcnt = 0; wcnt = 0; vcnt = -1;
    forever begin
      @(negedge clk);
      rd_0_ack = 1'b0; rd_0_vld = 1'b0; wr_0_ack = 1'b0;
      rd_0_data = 72'hDEAD_DEAD;
      rcnt = (rd_0_req === 1'b1 && sram_en) ? rcnt + 1 : 0;
      wcnt = (wr_0_req === 1'b1 && sram_en) ? wcnt + 1 : 0;
      if (vcnt > 0) begin
        vcnt--;
        if (vcnt == 0) begin
          rd_0_vld = 1'b1; rd_0_data = rd_val; vcnt = -1;
        end
      end
      if (rcnt == ack_lat + 1) begin
        rd_0_ack = 1'b1;
        check("rd_0_addr", 256'(rd_0_addr), 256'(exp_rd_addr));
        if (vld_lat == 0) begin
          rd_0_vld = 1'b1; rd_0_data = rd_val;
        end else begin
          vcnt = vld_lat;
        end
      end
      if (wcnt == wack_lat + 1) begin
        wr_0_ack = 1'b1;
        check("wr_0_addr", 256'(wr_0_addr), 256'(exp_wr_addr));
        check("wr_0_data", 256'(wr_0_data), 256'(exp_wr_data));
      end
    end
  end

  // monitor: pops expectations whenever the DUT pulses a grant or completion
  always @(negedge clk) begin
    if (reset) begin
      if (wr_0_req) wr_hi++;
      if (lk_gnt || cfg_gnt) begin
        if (lk_gnt && cfg_gnt) check("dual_gnt", {lk_gnt, cfg_gnt}, 2'b10);
        else if (exp_gnt.size() == 0) check("spurious_gnt", {lk_gnt, cfg_gnt}, 2'b00);
        else check("gnt_order", 256'(lk_gnt ? GL : GC), 256'(exp_gnt.pop_front()));
      end
      if (lk_vld || cfg_done) begin
        if (exp_rsp.size() == 0) check("spurious_rsp", {lk_vld, cfg_done}, 2'b00);
        else begin
          rsp_t e;
          e = exp_rsp.pop_front();
          check("rsp_owner", {lk_vld, cfg_done}, e.is_cfg ? 2'b01 : 2'b10);
          check("rsp_err", 256'(rsp_err), 256'(e.err));
          if (e.chk_data) check("rsp_data", 256'(rsp_data), 256'(e.data));
        end
      end
    end
  end

  function automatic logic [255:0] all_outs();
    return 256'({lk_gnt, lk_vld, cfg_gnt, cfg_done, rsp_data, rsp_err,
                 rd_0_req, rd_0_addr, wr_0_req, wr_0_addr, wr_0_data});
  endfunction

  task automatic wait_gnt();
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (lk_gnt || cfg_gnt) return;
    end
    n_checks++; n_fail++;
    $display("FAIL gnt_wait: got no grant expected grant within 50 cycles");
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100; i++) begin
      if (exp_rsp.size() == 0 && exp_gnt.size() == 0) begin
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    n_checks++; n_fail++;
    $display("FAIL drain_wait: got %0d pending expected 0", exp_rsp.size() + exp_gnt.size());
  endtask

  task automatic lookup(input logic [AW-1:0] a, input logic [DW-1:0] d, input int al, input int vl);
    ack_lat = al; vld_lat = vl; rd_val = d; exp_rd_addr = a;
    exp_gnt.push_back(GL);
    exp_rsp.push_back('{is_cfg: 1'b0, chk_data: 1'b1, data: d, err: 1'b0});
    lk_req = 1'b1; lk_addr = a;
    wait_gnt();
    lk_req = 1'b0;
    wait_drain();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 check("reset_outputs", all_outs(), '0);
    @(negedge clk); reset = 1'b1;
    repeat (2) @(posedge clk); #1;

    // basic lookup with ack 2 cycles and data 1 cycle after ack
    lookup(19'h00010, 72'hAB, 2, 1);

    // config write: ack one cycle after request rises -> request high 2 cycles
    wack_lat = 1; exp_wr_addr = 19'h7FFFF; exp_wr_data = '1; wr_hi = 0;
    exp_gnt.push_back(GC);
    exp_rsp.push_back('{is_cfg: 1'b1, chk_data: 1'b0, data: '0, err: 1'b0});
    cfg_req = 1'b1; cfg_rd_wr_L = 1'b0; cfg_addr = 19'h7FFFF; cfg_wr_data = '1;
    wait_gnt();
    cfg_req = 1'b0;
    wait_drain();
    check("wr_req_cycles", 256'(wr_hi), 256'd2);

    // config read, zero-wait; response data must hold afterwards
    ack_lat = 0; vld_lat = 0; rd_val = 72'h12_3456_789A_BCDE_F012; exp_rd_addr = 19'h12345;
    exp_gnt.push_back(GC);
    exp_rsp.push_back('{is_cfg: 1'b1, chk_data: 1'b1, data: 72'h12_3456_789A_BCDE_F012, err: 1'b0});
    cfg_req = 1'b1; cfg_rd_wr_L = 1'b1; cfg_addr = 19'h12345;
    wait_gnt();
    cfg_req = 1'b0;
    wait_drain();
    repeat (3) @(posedge clk); #1;
    check("rsp_data_hold", 256'(rsp_data), 256'(72'h12_3456_789A_BCDE_F012));

    // both requesting with zero-wait SRAM: L,L,L,L,C repeated, grants 3 cycles apart
    ack_lat = 0; vld_lat = 0; wack_lat = 0; rd_val = 72'h55; exp_rd_addr = 19'h00100;
    exp_wr_addr = 19'h00200; exp_wr_data = 72'h77;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        exp_gnt.push_back(GL);
        exp_rsp.push_back('{is_cfg: 1'b0, chk_data: 1'b1, data: 72'h55, err: 1'b0});
      end
      exp_gnt.push_back(GC);
      exp_rsp.push_back('{is_cfg: 1'b1, chk_data: 1'b0, data: '0, err: 1'b0});
    end
    lk_addr = 19'h00100; cfg_addr = 19'h00200; cfg_wr_data = 72'h77; cfg_rd_wr_L = 1'b0;
    lk_req = 1'b1; cfg_req = 1'b1;
    begin
      int cyc, n, last;
      cyc = 0; n = 0; last = -1;
      while (n < 10 && cyc < 200) begin
        @(posedge clk); #1; cyc++;
        if (lk_gnt || cfg_gnt) begin
          if (last >= 0) check("issue_gap", 256'(cyc - last), 256'd3);
          last = cyc; n++;
        end
      end
      lk_req = 1'b0; cfg_req = 1'b0;
      check("arb_grant_count", 256'(n), 256'd10);
    end
    wait_drain();

`ifdef ARB_TIMEOUT_EN
    // SRAM never acks: watchdog aborts 255 cycles after the grant
    sram_en = 1'b0;
    exp_gnt.push_back(GL);
    exp_rsp.push_back('{is_cfg: 1'b0, chk_data: 1'b1, data: '0, err: 1'b1});
    lk_req = 1'b1; lk_addr = 19'h00005;
    wait_gnt();
    lk_req = 1'b0;
    begin
      int c;
      for (c = 1; c < 400; c++) begin
        @(posedge clk); #1;
        if (lk_vld) break;
      end
      check("timeout_latency", 256'(c), 256'd255);
      check("timeout_rd_req", 256'(rd_0_req), 256'd0);
    end
    sram_en = 1'b1;
    wait_drain();
`else
    // SRAM never acks: arbiter keeps waiting, recovered only by reset
    sram_en = 1'b0;
    exp_gnt.push_back(GL);
    lk_req = 1'b1; lk_addr = 19'h00005;
    wait_gnt();
    lk_req = 1'b0;
    repeat (300) @(posedge clk); #1;
    check("no_timeout_rd_req", 256'(rd_0_req), 256'd1);
    check("no_timeout_err", 256'(rsp_err), 256'd0);
    #2 reset = 1'b0;
    #1 check("stuck_reset_outputs", all_outs(), '0);
    @(posedge clk); #2 reset = 1'b1;
    sram_en = 1'b1;
    wait_drain();
`endif

    // reset while waiting for read data: no completion, later vld ignored
    ack_lat = 0; vld_lat = 6; rd_val = 72'hBAD; exp_rd_addr = 19'h00033;
    exp_gnt.push_back(GL);
    lk_req = 1'b1; lk_addr = 19'h00033;
    wait_gnt();
    lk_req = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    #1 check("mid_reset_outputs", all_outs(), '0);
    @(posedge clk); #2 reset = 1'b1;
    repeat (10) @(posedge clk); #1;
    check("idle_vld_ignored", 256'(rsp_data), 256'd0);

    // normal operation resumes after reset
    lookup(19'h0ABCD, 72'hC0FFEE, 1, 0);

    check("leftover_rsp", 256'(exp_rsp.size()), 256'd0);
    check("leftover_gnt", 256'(exp_gnt.size()), 256'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_rule_arbiter.md
SRAM_RULE_ARBITER -- requirements
Module: sram_rule_arbiter

Interface
REQ-001 SHALL have parameter SRAM_ADDR_WIDTH, default 19, SRAM word address width.
REQ-002 SHALL have parameter SRAM_DATA_WIDTH, default 72, SRAM word width.
REQ-003 SHALL have parameter MAX_LOOKUP_STREAK, default 4, consecutive lookup grants allowed while cfg waits.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, watchdog limit in cycles.
REQ-005 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port lk_req  in  1  lookup read request, level.
REQ-008 SHALL have port lk_addr  in  SRAM_ADDR_WIDTH  lookup address.
REQ-009 SHALL have port lk_gnt  out  1  one-cycle pulse: lookup accepted.
REQ-010 SHALL have port lk_vld  out  1  one-cycle pulse: lookup response on rsp_data.
REQ-011 SHALL have port cfg_req  in  1  config request, level.
REQ-012 SHALL have port cfg_rd_wr_L  in  1  1 = read, 0 = write.
REQ-013 SHALL have port cfg_addr  in  SRAM_ADDR_WIDTH  config address.
REQ-014 SHALL have port cfg_wr_data  in  SRAM_DATA_WIDTH  config write data.
REQ-015 SHALL have port cfg_gnt  out  1  one-cycle pulse: config accepted.
REQ-016 SHALL have port cfg_done  out  1  one-cycle pulse: config complete; read data on rsp_data.
REQ-017 SHALL have port rsp_data  out  SRAM_DATA_WIDTH  response data, qualified by lk_vld/cfg_done.
REQ-018 SHALL have port rsp_err  out  1  timeout flag, qualified by lk_vld/cfg_done.
REQ-019 SHALL have port rd_0_req  out  1  SRAM read request, held until ack.
REQ-020 SHALL have port rd_0_addr  out  SRAM_ADDR_WIDTH  SRAM read address.
REQ-021 SHALL have port rd_0_data  in  SRAM_DATA_WIDTH  SRAM read data.
REQ-022 SHALL have port rd_0_ack  in  1  SRAM read accepted.
REQ-023 SHALL have port rd_0_vld  in  1  SRAM read data valid.
REQ-024 SHALL have port wr_0_req  out  1  SRAM write request, held until ack.
REQ-025 SHALL have ports wr_0_addr  out  SRAM_ADDR_WIDTH and wr_0_data  out  SRAM_DATA_WIDTH  SRAM write address/data.
REQ-026 SHALL have port wr_0_ack  in  1  SRAM write accepted.

Function
REQ-027 SHALL implement states IDLE, RD_REQ, RD_DATA, WR_REQ; one transaction outstanding at a time; all outputs registered.
REQ-028 In IDLE with a request: grant pulse, capture addr/data/owner, go RD_REQ (read) or WR_REQ (cfg write); rd_0_req/wr_0_req high from next cycle.
REQ-029 Both requesting: lookup wins unless streak == MAX_LOOKUP_STREAK, then cfg wins.
REQ-030 Streak increments (saturating) per lookup grant while cfg_req high; clears on cfg grant or cfg_req low.
REQ-031 RD_REQ: hold rd_0_req/rd_0_addr until rd_0_ack sampled, deassert next cycle, go RD_DATA; ack and vld together go straight to completion.
REQ-032 RD_DATA: on rd_0_vld capture rd_0_data, pulse owner's lk_vld/cfg_done next cycle with rsp_err=0, return IDLE.
REQ-033 WR_REQ: hold wr_0_req/addr/data until wr_0_ack, then cfg_done pulse next cycle, rsp_err=0, return IDLE.
REQ-034 Returning to IDLE, new grant may issue in the completion-pulse cycle; min issue-to-issue 3 cycles.
REQ-035 rd_0_vld/ack/wr_0_ack while IDLE SHALL be ignored; rsp_data holds last value between pulses.

Reset
REQ-036 reset low: immediately state IDLE, streak 0, watchdog 0, every output 0, regardless of cycle.
REQ-037 Transaction interrupted by reset SHALL be discarded; no completion pulse afterwards.

Configuration
REQ-038 With ARB_TIMEOUT_EN defined: watchdog counts cycles outside IDLE; at TIMEOUT_CYCLES deassert SRAM request, pulse owner's completion with rsp_err=1, rsp_data=0, return IDLE.
REQ-039 Without ARB_TIMEOUT_EN: no watchdog, waits indefinitely, rsp_err tied 0, TIMEOUT_CYCLES unused.

Verification
REQ-040 lk_req, lk_addr=0x00010, ack 2 cycles later, vld 3 later, data 0xAB -> lk_gnt 1 pulse, rd_0_addr=0x00010, lk_vld once, rsp_data=0xAB, rsp_err=0.
REQ-041 cfg write addr=0x7FFFF data=all-ones, wr_0_ack after 1 cycle -> wr_0_req exactly 2 cycles, cfg_done once.
REQ-042 lk_req and cfg_req held, zero-wait SRAM -> grant order L,L,L,L,C,L,L,L,L,C.
REQ-043 With ARB_TIMEOUT_EN, rd_0_ack never returned -> after 255 cycles rd_0_req low, lk_vld with rsp_err=1, rsp_data=0.
REQ-044 reset low during RD_DATA, then vld -> all outputs 0 at once, no lk_vld, next lk_req granted normally.
